// File: rtl/handshake_stream_capture_pkg.sv
// Shared definitions for the stream capture block.
// Provides the pointer-width and stall-counter-width helpers and the
// saturating increment used by both event counters.
package handshake_stream_capture_pkg;

    // Stall counter is a fixed 8-bit counter so stall_period can span 1..255.
    localparam int STALL_CNT_WIDTH = 8;

    // Ceiling log2 evaluated at elaboration time for parameter sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Read/write pointers carry one extra wrap bit above the address.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    // Callers widen to 64 bits going in and truncate coming out.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/handshake_capture_fifo.sv
// Small power-of-two FIFO buffering accepted tokens for the drain side.
// Ports:
//   clk, rst        clock, synchronous active-low reset (pointers only)
//   push, push_data write one entry (caller guarantees not full)
//   pop             read one entry (caller guarantees not empty)
//   head_data       asynchronous read of the oldest entry
//   full, empty     occupancy flags from the wrap-bit pointer compare
module handshake_capture_fifo
    import handshake_stream_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_WIDTH  = ptr_width(DEPTH);
    localparam int ADDR_WIDTH = PTR_WIDTH - 1;

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Same address with opposite wrap bits means the writer lapped the reader.
    assign full  = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign head_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Pointers advance independently and wrap naturally at 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
        end
    end

    // Storage is left unreset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/handshake_stream_capture.sv
// Terminal consumer for a valid/ready token stream: buffers tokens in a FIFO
// for a drain-side reader, injects periodic back-pressure stalls, counts
// accepted tokens and checks them against an expected payload.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   ins, ins_valid, ins_ready    input token channel
//   drain_data/valid/ready       FIFO read-out channel
//   stall_period                 accepts between one-cycle stalls (0 = off)
//   expect_en, expect_value      token compare enable and reference payload
//   clear                        zero counters, flags and stall counter
//   token_count                  accepted tokens (saturating)
//   mismatch, mismatch_count     sticky compare flag and failure count
//   first_bad                    payload of the first mismatching token
module handshake_stream_capture
    import handshake_stream_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] drain_data,
    output logic                  drain_valid,
    input  logic                  drain_ready,
    input  logic [7:0]            stall_period,
    input  logic                  expect_en,
    input  logic [DATA_WIDTH-1:0] expect_value,
    input  logic                  clear,
    output logic [CNT_WIDTH-1:0]  token_count,
    output logic                  mismatch,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic [DATA_WIDTH-1:0] first_bad
);

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       accept;
    logic                       pop;
    logic                       bad_token;
    logic                       stall_now;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0]       token_count_inc;
    logic [CNT_WIDTH-1:0]       mismatch_count_inc;

    // Ready comes only from registered state (and reset), so there is no
    // combinational path from ins_valid back to ins_ready.
    assign ins_ready   = !fifo_full && !stall_now && rst;
    assign accept      = ins_valid && ins_ready;
    assign drain_valid = !fifo_empty;
    assign pop         = drain_valid && drain_ready;
    assign bad_token   = accept && expect_en && (ins != expect_value);

    assign token_count_inc    = CNT_WIDTH'(sat_inc(64'(token_count), CNT_WIDTH));
    assign mismatch_count_inc = CNT_WIDTH'(sat_inc(64'(mismatch_count), CNT_WIDTH));

    handshake_capture_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (ins),
        .pop       (pop),
        .head_data (drain_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Stall injection: an equality compare against the current period, so a
    // period lowered below the running count only fires after the 8-bit wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            stall_now <= 1'b0;
        end else begin
            stall_now <= 1'b0;
            if (clear) begin
                stall_cnt <= '0;
            end else if (accept) begin
                if ((stall_period != 8'd0) && (stall_cnt == stall_period - 8'd1)) begin
                    stall_now <= 1'b1;
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 8'd1;
                end
            end
        end
    end

    // Counters and compare; clear takes priority over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            token_count    <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            first_bad      <= '0;
        end else if (clear) begin
            token_count    <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            first_bad      <= '0;
        end else begin
            if (accept) begin
                token_count <= token_count_inc;
            end
            if (bad_token) begin
                mismatch       <= 1'b1;
                mismatch_count <= mismatch_count_inc;
                if (!mismatch) begin
                    first_bad <= ins;
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_stream_capture.sv
// Testbench for handshake_stream_capture. Two instances share all inputs:
// one with 16-bit counters and one with 4-bit counters to exercise
// saturation. A cycle model with a payload queue predicts every output.
module tb_handshake_stream_capture;

    localparam int DW    = 18;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          drain_ready;
    logic [7:0]    stall_period;
    logic          expect_en;
    logic [DW-1:0] expect_value;
    logic          clear;

    logic          ins_ready,      s_ins_ready;
    logic [DW-1:0] drain_data,     s_drain_data;
    logic          drain_valid,    s_drain_valid;
    logic [15:0]   token_count,    mismatch_count;
    logic [3:0]    s_token_count,  s_mismatch_count;
    logic          mismatch,       s_mismatch;
    logic [DW-1:0] first_bad,      s_first_bad;

    // Bench-side model state
    logic [DW-1:0] m_q[$];
    int            m_stall_cnt;
    bit            m_stall_now;
    int            m_tok;
    int            m_mm_cnt;
    bit            m_mm;
    logic [DW-1:0] m_fb;
    bit            checks_on = 1'b0;
    bit            last_accept;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    handshake_stream_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .drain_data(drain_data), .drain_valid(drain_valid), .drain_ready(drain_ready),
        .stall_period(stall_period), .expect_en(expect_en), .expect_value(expect_value),
        .clear(clear), .token_count(token_count), .mismatch(mismatch),
        .mismatch_count(mismatch_count), .first_bad(first_bad)
    );

    handshake_stream_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(s_ins_ready),
        .drain_data(s_drain_data), .drain_valid(s_drain_valid), .drain_ready(drain_ready),
        .stall_period(stall_period), .expect_en(expect_en), .expect_value(expect_value),
        .clear(clear), .token_count(s_token_count), .mismatch(s_mismatch),
        .mismatch_count(s_mismatch_count), .first_bad(s_first_bad)
    );

    function automatic int clip(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_stall_cnt = 0;
        m_stall_now = 1'b0;
        m_tok       = 0;
        m_mm_cnt    = 0;
        m_mm        = 1'b0;
        m_fb        = '0;
    endtask

    // One clock cycle: settle, compare every output against the model,
    // advance the model with the current inputs, then step past the edge.
    task automatic applyStimulus();
        bit exp_ready;
        bit popd;
        #1;
        exp_ready = rst && !m_stall_now && (m_q.size() < DEPTH);
        if (checks_on) begin
            checkOutput("ins_ready",       64'(ins_ready),        64'(exp_ready));
            checkOutput("sat_ins_ready",   64'(s_ins_ready),      64'(exp_ready));
            checkOutput("drain_valid",     64'(drain_valid),      64'(m_q.size() != 0));
            checkOutput("sat_drain_valid", 64'(s_drain_valid),    64'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                checkOutput("drain_data",     64'(drain_data),   64'(m_q[0]));
                checkOutput("sat_drain_data", 64'(s_drain_data), 64'(m_q[0]));
            end
            checkOutput("token_count",        64'(token_count),      64'(clip(m_tok, 65535)));
            checkOutput("sat_token_count",    64'(s_token_count),    64'(clip(m_tok, 15)));
            checkOutput("mismatch_count",     64'(mismatch_count),   64'(clip(m_mm_cnt, 65535)));
            checkOutput("sat_mismatch_count", 64'(s_mismatch_count), 64'(clip(m_mm_cnt, 15)));
            checkOutput("mismatch",           64'(mismatch),         64'(m_mm));
            checkOutput("first_bad",          64'(first_bad),        64'(m_fb));
        end
        last_accept = ins_valid && exp_ready;
        popd        = rst && (m_q.size() != 0) && drain_ready;
        if (!rst) begin
            modelReset();
            last_accept = 1'b0;
        end else begin
            if (popd) begin
                void'(m_q.pop_front());
            end
            if (last_accept) begin
                m_q.push_back(ins);
            end
            m_stall_now = 1'b0;
            if (clear) begin
                m_stall_cnt = 0;
                m_tok       = 0;
                m_mm_cnt    = 0;
                m_mm        = 1'b0;
                m_fb        = '0;
            end else if (last_accept) begin
                if (stall_period != 8'd0 && m_stall_cnt == int'(stall_period) - 1) begin
                    m_stall_now = 1'b1;
                    m_stall_cnt = 0;
                end else begin
                    m_stall_cnt = (m_stall_cnt + 1) % 256;
                end
                m_tok++;
                if (expect_en && ins != expect_value) begin
                    if (!m_mm) m_fb = ins;
                    m_mm = 1'b1;
                    m_mm_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] next_val;
        logic [DW-1:0] exp_tokens [5];
        int            accepts;

        rst = 1'b0; ins = '0; ins_valid = 1'b0; drain_ready = 1'b0;
        stall_period = 8'd0; expect_en = 1'b0; expect_value = '0; clear = 1'b0;

        // Reset then idle
        @(posedge clk);
        #1;
        modelReset();
        checks_on = 1'b1;
        applyStimulus();
        checkOutput("reset_ready_low", 64'(ins_ready), 64'd0);
        checkOutput("reset_drain_valid", 64'(drain_valid), 64'd0);
        checkOutput("reset_token_count", 64'(token_count), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_reset", 64'(ins_ready), 64'd1);

        // Fill with drain stalled, then single-cycle pop
        $display("[TB] fill and backpressure");
        ins_valid = 1'b1;
        next_val  = 18'h11;
        accepts   = 0;
        for (int i = 0; i < 10 && accepts < 4; i++) begin
            ins = next_val;
            applyStimulus();
            if (last_accept) begin
                next_val++;
                accepts++;
            end
        end
        ins = 18'h15;
        checkOutput("full_ready_low", 64'(ins_ready), 64'd0);
        checkOutput("full_head", 64'(drain_data), 64'h11);
        drain_ready = 1'b1;
        applyStimulus();
        drain_ready = 1'b0;
        checkOutput("ready_after_pop", 64'(ins_ready), 64'd1);
        checkOutput("head_after_pop", 64'(drain_data), 64'h12);
        applyStimulus();
        ins_valid   = 1'b0;
        drain_ready = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("fill_drained", 64'(drain_valid), 64'd0);
        checkOutput("fill_token_count", 64'(token_count), 64'd5);

        // Streaming with periodic stalls
        $display("[TB] streaming with stall_period=3");
        clear = 1'b1;
        applyStimulus();
        clear        = 1'b0;
        stall_period = 8'd3;
        ins_valid    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ins = DW'(32'h100 + i);
            checkOutput("stall_pattern", 64'(ins_ready), 64'((i % 4) != 3));
            applyStimulus();
        end
        ins_valid = 1'b0;
        checkOutput("stream_token_count", 64'(token_count), 64'd30);
        checkOutput("stream_sat_count", 64'(s_token_count), 64'd15);

        // Expected-value check
        $display("[TB] expected-value compare");
        stall_period = 8'd0;
        clear        = 1'b1;
        applyStimulus();
        clear        = 1'b0;
        expect_en    = 1'b1;
        expect_value = 18'h3FD46;
        exp_tokens   = '{18'h3FD46, 18'h3FD46, 18'h3FD46, 18'h00001, 18'h00002};
        ins_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ins = exp_tokens[i];
            applyStimulus();
        end
        ins_valid = 1'b0;
        checkOutput("cmp_mismatch", 64'(mismatch), 64'd1);
        checkOutput("cmp_mismatch_count", 64'(mismatch_count), 64'd2);
        checkOutput("cmp_first_bad", 64'(first_bad), 64'h00001);
        checkOutput("cmp_token_count", 64'(token_count), 64'd5);
        applyStimulus();
        applyStimulus();

        // Clear colliding with a mismatching accept
        $display("[TB] clear collision");
        drain_ready = 1'b0;
        ins         = 18'h00BAD;
        ins_valid   = 1'b1;
        clear       = 1'b1;
        applyStimulus();
        ins_valid = 1'b0;
        clear     = 1'b0;
        checkOutput("clr_token_count", 64'(token_count), 64'd0);
        checkOutput("clr_mismatch", 64'(mismatch), 64'd0);
        checkOutput("clr_mismatch_count", 64'(mismatch_count), 64'd0);
        checkOutput("clr_first_bad", 64'(first_bad), 64'd0);
        checkOutput("clr_token_kept", 64'(drain_data), 64'h00BAD);

        // Saturation and pointer wrap
        $display("[TB] saturation and wrap");
        expect_en   = 1'b0;
        drain_ready = 1'b1;
        ins_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ins = DW'($urandom);
            applyStimulus();
        end
        ins_valid = 1'b0;
        checkOutput("sat_full_count", 64'(token_count), 64'd20);
        checkOutput("sat_held_count", 64'(s_token_count), 64'd15);

        // Random traffic with shifting stall period
        $display("[TB] random traffic");
        expect_en    = 1'b1;
        expect_value = DW'($urandom);
        for (int i = 0; i < 60; i++) begin
            ins_valid    = 1'($urandom_range(0, 1));
            ins          = DW'($urandom);
            drain_ready  = 1'($urandom_range(0, 1));
            stall_period = 8'($urandom_range(0, 2));
            applyStimulus();
        end

        // Reset while tokens are buffered
        $display("[TB] mid-transfer reset");
        ins_valid    = 1'b0;
        stall_period = 8'd0;
        drain_ready  = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus();
        drain_ready = 1'b0;
        ins_valid   = 1'b1;
        accepts     = 0;
        for (int i = 0; i < 6 && accepts < 2; i++) begin
            ins = DW'(18'h2A0 + i);
            applyStimulus();
            if (last_accept) accepts++;
        end
        rst         = 1'b0;
        drain_ready = 1'b1;
        applyStimulus();
        rst         = 1'b1;
        ins_valid   = 1'b0;
        drain_ready = 1'b0;
        #1;
        checkOutput("rst_discard", 64'(drain_valid), 64'd0);
        checkOutput("rst_ready", 64'(ins_ready), 64'd1);
        ins       = 18'h1234;
        ins_valid = 1'b1;
        applyStimulus();
        ins_valid = 1'b0;
        checkOutput("post_rst_head", 64'(drain_data), 64'h1234);

        // Final drain
        drain_ready = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus();
        checkOutput("final_empty", 64'(m_q.size()), 64'd0);
        checkOutput("final_drain_valid", 64'(drain_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
